// File: rtl/barrel_shifter_pipe.sv
// Parametrised barrel shifter with one level per shift-amount bit.
// Levels are registered (PIPE=1) or chained into one output register (PIPE=0).
module barrel_shifter_pipe #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int PIPE    = 1
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               In_Valid,
  output logic               In_Ready,
  input  logic [2:0]         Mode,
  input  logic [SHAMT_W-1:0] Shift_Amount,
  input  logic [WIDTH-1:0]   Data_In,
  output logic               Out_Valid,
  input  logic               Out_Ready,
  output logic [WIDTH-1:0]   Data_Out,
  output logic               Zero,
  output logic               Carry_Out
);

  typedef struct packed {
    logic               vld;
    logic [2:0]         mode;
    logic [SHAMT_W-1:0] amt;
    logic [WIDTH-1:0]   data;
    logic               cy;
    logic               zf;
  } beat_t;

  // The last bit moved out across the whole shift is the one moved out by
  // the highest active level, for shifts and rotates alike.
  function automatic beat_t step(beat_t b, int k);
    beat_t r;
    int    d;
    r = b;
    d = 1 << k;
    if (b.amt[k]) begin
      unique case (b.mode)
        3'b000: begin
          r.data = b.data << d;
          r.cy   = b.data[SHAMT_W'(WIDTH-d)];
        end
        3'b001: begin
          r.data = b.data >> d;
          r.cy   = b.data[SHAMT_W'(d-1)];
        end
        3'b010: begin
          r.data = $signed(b.data) >>> d;
          r.cy   = b.data[SHAMT_W'(d-1)];
        end
        3'b011: begin
          r.data = (b.data << d) | (b.data >> (WIDTH-d));
          r.cy   = b.data[SHAMT_W'(WIDTH-d)];
        end
        3'b100: begin
          r.data = (b.data >> d) | (b.data << (WIDTH-d));
          r.cy   = b.data[SHAMT_W'(d-1)];
        end
        default: r.data = b.data;
      endcase
    end
    r.zf = (r.data == '0);
    return r;
  endfunction

  logic  stall;
  beat_t head;

  assign stall    = Out_Valid & ~Out_Ready;
  assign In_Ready = ~stall;

  always_comb begin
    head      = '0;
    head.vld  = In_Valid & In_Ready;
    head.mode = Mode;
    head.amt  = Shift_Amount;
    head.data = Data_In;
  end

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_lvl
    beat_t stage_in;
    beat_t stage_d;
    beat_t stage_q;

    if (k == 0) begin : g_head
      assign stage_in = head;
    end else begin : g_link
      assign stage_in = g_lvl[k-1].stage_q;
    end

    always_comb stage_d = step(stage_in, k);

    if (PIPE != 0 || k == SHAMT_W-1) begin : g_reg
      // Bubbles still advance valid; payload only loads with a real beat.
      always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
          stage_q <= '0;
        end else if (!stall) begin
          stage_q.vld <= stage_d.vld;
          if (stage_d.vld) stage_q <= stage_d;
        end
      end
    end else begin : g_comb
      assign stage_q = stage_d;
    end
  end

  assign Out_Valid = g_lvl[SHAMT_W-1].stage_q.vld;
  assign Data_Out  = g_lvl[SHAMT_W-1].stage_q.data;
  assign Zero      = g_lvl[SHAMT_W-1].stage_q.zf;
  assign Carry_Out = g_lvl[SHAMT_W-1].stage_q.cy;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed bench for barrel_shifter_pipe: PIPE=1 and PIPE=0 instances
// share clock, reset and operand inputs; valid/ready are per instance.
module tb_barrel_shifter_pipe;

  logic        clk;
  logic        rst;
  logic [2:0]  mode;
  logic [3:0]  amt;
  logic [15:0] din;

  logic        iv_a, ir_a, ov_a, or_a, zf_a, cy_a;
  logic [15:0] do_a;
  logic        iv_b, ir_b, ov_b, or_b, zf_b, cy_b;
  logic [15:0] do_b;

  int n_cmp = 0;
  int n_bad = 0;

  barrel_shifter_pipe #(.WIDTH(16), .PIPE(1)) u_pipe (
    .Clock(clk), .Reset(rst),
    .In_Valid(iv_a), .In_Ready(ir_a),
    .Mode(mode), .Shift_Amount(amt), .Data_In(din),
    .Out_Valid(ov_a), .Out_Ready(or_a),
    .Data_Out(do_a), .Zero(zf_a), .Carry_Out(cy_a)
  );

  barrel_shifter_pipe #(.WIDTH(16), .PIPE(0)) u_comb (
    .Clock(clk), .Reset(rst),
    .In_Valid(iv_b), .In_Ready(ir_b),
    .Mode(mode), .Shift_Amount(amt), .Data_In(din),
    .Out_Valid(ov_b), .Out_Ready(or_b),
    .Data_Out(do_b), .Zero(zf_b), .Carry_Out(cy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stream table: mode, amount, operand, result, carry, zero.
  logic [2:0]  v_mode [8];
  logic [3:0]  v_amt  [8];
  logic [15:0] v_din  [8];
  logic [15:0] v_res  [8];
  logic        v_cy   [8];
  logic        v_zf   [8];

  task automatic set_vec(input int i, input logic [2:0] m,
                         input logic [3:0] a, input logic [15:0] d,
                         input logic [15:0] r, input logic c,
                         input logic z);
    v_mode[i] = m; v_amt[i] = a; v_din[i] = d;
    v_res[i]  = r; v_cy[i]  = c; v_zf[i]  = z;
  endtask

  task automatic drive(input int i);
    mode = v_mode[i];
    amt  = v_amt[i];
    din  = v_din[i];
  endtask

  // One beat into both instances; checks result and latency of each.
  task automatic send_one(input string tag, input logic [2:0] m,
                          input logic [3:0] a, input logic [15:0] d,
                          input logic [15:0] r, input logic c,
                          input logic z);
    int lat, la, lb;
    @(negedge clk);
    mode = m; amt = a; din = d;
    iv_a = 1'b1; iv_b = 1'b1;
    chk({tag, "_rdy_a"}, 32'(ir_a), 32'd1);
    chk({tag, "_rdy_b"}, 32'(ir_b), 32'd1);
    @(negedge clk);
    iv_a = 1'b0; iv_b = 1'b0;
    lat = 1; la = 0; lb = 0;
    while (lat <= 12 && (la == 0 || lb == 0)) begin
      if (ov_a && la == 0) begin
        la = lat;
        chk({tag, "_data_a"}, 32'(do_a), 32'(r));
        chk({tag, "_cy_a"}, 32'(cy_a), 32'(c));
        chk({tag, "_zf_a"}, 32'(zf_a), 32'(z));
      end
      if (ov_b && lb == 0) begin
        lb = lat;
        chk({tag, "_data_b"}, 32'(do_b), 32'(r));
        chk({tag, "_cy_b"}, 32'(cy_b), 32'(c));
        chk({tag, "_zf_b"}, 32'(zf_b), 32'(z));
      end
      if (la == 0 || lb == 0) begin
        @(negedge clk);
        lat++;
      end
    end
    chk({tag, "_lat_a"}, 32'(la), 32'd4);
    chk({tag, "_lat_b"}, 32'(lb), 32'd1);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int j, cyc, seen;
    logic [15:0] hold;
    logic stalled;

    rst = 1'b1;
    iv_a = 1'b0; iv_b = 1'b0;
    or_a = 1'b1; or_b = 1'b1;
    mode = 3'b000; amt = 4'd0; din = 16'h0000;

    set_vec(0, 3'b000, 4'd3,  16'h0001, 16'h0008, 1'b0, 1'b0);
    set_vec(1, 3'b001, 4'd8,  16'h0080, 16'h0000, 1'b1, 1'b1);
    set_vec(2, 3'b010, 4'd12, 16'hF000, 16'hFFFF, 1'b0, 1'b0);
    set_vec(3, 3'b011, 4'd4,  16'h1234, 16'h2341, 1'b1, 1'b0);
    set_vec(4, 3'b100, 4'd4,  16'h1234, 16'h4123, 1'b0, 1'b0);
    set_vec(5, 3'b000, 4'd15, 16'hFFFF, 16'h8000, 1'b1, 1'b0);
    set_vec(6, 3'b001, 4'd15, 16'h8000, 16'h0001, 1'b0, 1'b0);
    set_vec(7, 3'b111, 4'd3,  16'hABCD, 16'hABCD, 1'b0, 1'b0);

    // Reset sanity
    @(negedge clk);
    chk("rst_ov", 32'(ov_a), 32'd0);
    chk("rst_do", 32'(do_a), 32'd0);
    chk("rst_zf", 32'(zf_a), 32'd0);
    chk("rst_cy", 32'(cy_a), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", 32'(ir_a), 32'd1);

    // Shift modes, rotates, pass-through on both builds
    send_one("lsl", 3'b000, 4'd1,  16'h8001, 16'h0002, 1'b1, 1'b0);
    send_one("asr", 3'b010, 4'd4,  16'h8000, 16'hF800, 1'b0, 1'b0);
    send_one("lsr", 3'b001, 4'd15, 16'h00F0, 16'h0000, 1'b0, 1'b1);
    send_one("ror", 3'b100, 4'd1,  16'h0001, 16'h8000, 1'b1, 1'b0);
    send_one("rol", 3'b011, 4'd4,  16'h8001, 16'h0018, 1'b0, 1'b0);
    send_one("pass", 3'b110, 4'd5, 16'h1234, 16'h1234, 1'b0, 1'b0);
    send_one("amt0", 3'b000, 4'd0, 16'h8001, 16'h8001, 1'b0, 1'b0);

    // Stream with backpressure into the pipelined build
    j = 0;
    fork
      begin
        int i;
        logic acc;
        i = 0;
        while (i < 8) begin
          @(negedge clk);
          drive(i);
          iv_a = 1'b1;
          #4;
          acc = ir_a;
          @(posedge clk);
          if (acc) i++;
        end
        @(negedge clk);
        iv_a = 1'b0;
      end
      begin
        stalled = 1'b0;
        cyc = 0;
        while (j < 8 && cyc < 80) begin
          @(negedge clk);
          cyc++;
          if (ov_a) begin
            if (!stalled) begin
              stalled = 1'b1;
              or_a = 1'b0;
              hold = do_a;
              repeat (3) begin
                @(negedge clk);
                chk("stall_rdy", 32'(ir_a), 32'd0);
                chk("stall_vld", 32'(ov_a), 32'd1);
                chk("stall_hold", 32'(do_a), 32'(hold));
              end
              or_a = 1'b1;
            end
            chk($sformatf("strm%0d_data", j), 32'(do_a), 32'(v_res[j]));
            chk($sformatf("strm%0d_cy", j), 32'(cy_a), 32'(v_cy[j]));
            chk($sformatf("strm%0d_zf", j), 32'(zf_a), 32'(v_zf[j]));
            j++;
          end
        end
      end
    join
    chk("strm_count", 32'(j), 32'd8);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ov_a) seen++;
    end
    chk("strm_extra", 32'(seen), 32'd0);

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(i + 3);
      iv_a = 1'b1;
    end
    @(negedge clk);
    iv_a = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("mrst_ov", 32'(ov_a), 32'd0);
    chk("mrst_do", 32'(do_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_rdy", 32'(ir_a), 32'd1);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ov_a) seen++;
    end
    chk("mrst_ghost", 32'(seen), 32'd0);
    send_one("post_rst", 3'b001, 4'd4, 16'hABCD, 16'h0ABC, 1'b1, 1'b0);

    // Sustained one beat per cycle through the PIPE=0 build
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("tput%0d_vld", i - 1), 32'(ov_b), 32'd1);
        chk($sformatf("tput%0d_data", i - 1), 32'(do_b), 32'(v_res[i-1]));
        chk($sformatf("tput%0d_cy", i - 1), 32'(cy_b), 32'(v_cy[i-1]));
      end
      if (i < 8) begin
        drive(i);
        iv_b = 1'b1;
        chk($sformatf("tput%0d_rdy", i), 32'(ir_b), 32'd1);
      end else begin
        iv_b = 1'b0;
      end
    end
    @(negedge clk);
    chk("tput_drain", 32'(ov_b), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/barrel_shifter_pipe.md
Name: barrel_shifter_pipe

Overview:
Parametrised, optionally pipelined barrel shifter with a valid/ready handshake on both sides.
- Supports logical left/right, arithmetic right, and rotate left/right.
- Produces zero and carry-out flags alongside the result.
- Sits in the datapath as the general shift unit feeding downstream ALU/formatting logic; replaces fixed-width, fixed-latency shifters.

Parameters:
- WIDTH, 16, data width in bits; power of two, minimum 4.
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived, do not override.
- PIPE, 1:
  - PIPE=1: one register stage per shift level, so latency = SHAMT_W cycles.
  - PIPE=0: all levels combinational plus a single output register, so latency = 1 cycle.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- In_Valid  input  1  input beat valid.
- In_Ready  output  1  block can accept a beat this cycle.
- Mode  input  3  operation select:
  - 000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR.
  - 101–111: pass-through.
- Shift_Amount  input  SHAMT_W  shift distance, 0..WIDTH-1.
- Data_In  input  WIDTH  operand.
- Out_Valid  output  1  result beat valid.
- Out_Ready  input  1  downstream accepts the result.
- Data_Out  output  WIDTH  shifted result.
- Zero  output  1  Data_Out == 0.
- Carry_Out  output  1  last bit shifted or rotated out.

Behaviour:
- Reset (async, immediate): Out_Valid=0, Data_Out=0, Zero=0, Carry_Out=0. All internal stage valids clear and in-flight beats are discarded. In_Ready=1 from the first cycle after Reset deasserts.
- Accept: a beat is accepted on a rising edge when In_Valid & In_Ready. Mode and Shift_Amount are captured with the data and carried down the pipeline; later changes to the inputs do not affect it.
- Stall: stall = Out_Valid & ~Out_Ready.
  - In_Ready = ~stall.
  - While stalled, every stage holds, and Data_Out/flags stay stable.
  - No bubble collapsing is required.
- Output: with no stall, a beat accepted at edge N appears with Out_Valid=1 after edge N+LATENCY.
- Throughput: one beat per cycle when Out_Ready is held high.
- Retire: a beat leaves when Out_Valid & Out_Ready. If no new beat reaches the last stage, Out_Valid drops next cycle; Data_Out may hold its stale value.
- Stage k (k = 0..SHAMT_W-1) shifts by 2^k when Shift_Amount[k]=1, otherwise passes through. Mode travels with the data.
- Fill rules:
  - LSL: zeros fill from the LSB.
  - LSR: zeros fill from the MSB.
  - ASR: copies of the original Data_In[WIDTH-1] fill from the MSB.
  - ROL/ROR: vacated bits come from the opposite end; the full circular rotate is evaluated modulo WIDTH.
- Carry_Out when Shift_Amount = 0: 0 for all modes.
- Carry_Out when Shift_Amount = s > 0:
  - LSL: Data_In[WIDTH-s].
  - LSR/ASR: Data_In[s-1].
  - ROL: Data_Out[0].
  - ROR: Data_Out[WIDTH-1].
  - Pass-through: 0.
- Pass-through modes (101–111): Data_Out = Data_In, with the same latency and flags.
- Zero is computed from the final result and registered with it; it is valid only while Out_Valid=1.
- Boundaries:
  - Shift_Amount = WIDTH-1 is the maximum. LSL/LSR leave one surviving bit. ASR yields all copies of the sign bit.
  - Back-to-back beats with different Mode values must not interfere.

Test Plan:
1. Reset sanity (WIDTH=16, PIPE=1): Reset pulse → Out_Valid=0, Data_Out=0x0000, Zero=0, Carry_Out=0; In_Ready=1 the cycle after release.
2. Shift modes, Out_Ready=1, one beat each:
   - LSL Data_In=0x8001 by 1 → 0x0002, Carry_Out=1, Zero=0, Out_Valid exactly 4 cycles after accept.
   - ASR 0x8000 by 4 → 0xF800, Carry_Out=0.
   - LSR 0x00F0 by 15 → 0x0000, Carry_Out=0, Zero=1.
3. Rotates and pass-through:
   - ROR 0x0001 by 1 → 0x8000, Carry_Out=1.
   - ROL 0x8001 by 4 → 0x0018, Carry_Out=0.
   - Mode=110 with 0x1234 by 5 → 0x1234, Carry_Out=0.
4. Throughput and backpressure: stream 8 beats with In_Valid held high; hold Out_Ready=0 for 3 cycles once Out_Valid rises → In_Ready=0 during the stall, Data_Out stable, no beat lost or duplicated, order preserved, 8 results total.
5. Reset mid-operation: assert Reset with 3 beats in flight → Out_Valid=0 immediately; none of those beats ever appears; the next beat accepted after release emerges with correct latency.
6. PIPE=0 build: the scenario 2 vectors give identical results with latency 1; sustained one beat per cycle with Out_Ready=1.
